zorro_axil_reg_arbiter: RTL and testbench

Shares the 32-bit AXI4-Lite register port of the MNTZorro core (S00_AXI, four word registers at 0x0/0x4/0x8/0xC) between two on-chip requesters, e.g. the PS-side bridge and the Zorro-side config engine. Each requester issues single-word read or write commands on a simple valid/done port. The block arbitrates round-robin and runs exactly one AXI4-Lite transaction at a time. It returns read data and error status to the granted requester.

---
 rtl/zorro_axil_reg_arbiter_if.sv | 39 +++
 rtl/zorro_axil_reg_arbiter.sv | 172 +++++++++++++++++
 tb/tb_zorro_axil_reg_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zorro_axil_reg_arbiter_if.sv
// zorro_axil_reg_arbiter_if
//   AXI4-Lite master-side bus of the register arbiter, 32-bit data.
//   AWPROT/ARPROT are not carried; the integration ties them to 3'b000.
// Parameter:
//   ADDR_W : byte address width
// Modports:
//   master : arbiter side (drives addr/data/valids, bready, rready)
//   slave  : register block side
interface zorro_axil_reg_arbiter_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/zorro_axil_reg_arbiter.sv
// zorro_axil_reg_arbiter
//   Shares the MNTZorro S00_AXI register port between two requesters.
//   Round-robin arbitration, one AXI4-Lite transaction at a time, single
//   word per command. All outputs are registered.
// Parameters:
//   ADDR_W  : byte address width (word aligned, bits [1:0] forced to 0)
//   TIMEOUT : watchdog limit in cycles (only with ZORRO_ARB_TIMEOUT_EN)
// Ports:
//   ACLK, ARESET   : clock, asynchronous active-high reset
//   rq_valid/rq_we : per-requester command request / write select
//   rq_addr        : packed addresses, ADDR_W bits per requester
//   rq_wdata       : packed write data, 32 bits per requester
//   rq_wstrb       : packed byte strobes, 4 bits per requester
//   rq_done/rq_err : one-cycle completion pulse and error to granted requester
//   rq_rdata       : read data, valid with rq_done, held until next completion
//   m_axi          : AXI4-Lite master bus (zorro_axil_reg_arbiter_if.master)
// Build option:
//   ZORRO_ARB_TIMEOUT_EN : when defined, a watchdog aborts a transaction after
//                          TIMEOUT cycles with rq_err=1 and rq_rdata=0.
module zorro_axil_reg_arbiter #(
   parameter int ADDR_W  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic [1:0]            rq_valid,
   input  logic [1:0]            rq_we,
   input  logic [2*ADDR_W-1:0]   rq_addr,
   input  logic [63:0]           rq_wdata,
   input  logic [7:0]            rq_wstrb,
   output logic [1:0]            rq_done,
   output logic [1:0]            rq_err,
   output logic [31:0]           rq_rdata,
   zorro_axil_reg_arbiter_if.master m_axi
);

   typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

   state_t            state;
   logic              last;
   logic              grant;

   logic              gnt;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic [3:0]        sel_wstrb;

   // Requester 1 wins when alone; on a tie the one not served last wins.
   always_comb begin
      gnt = rq_valid[1];
      if (rq_valid == 2'b11) gnt = ~last;
      sel_we    = gnt ? rq_we[1]                    : rq_we[0];
      sel_addr  = gnt ? rq_addr[2*ADDR_W-1:ADDR_W]  : rq_addr[ADDR_W-1:0];
      sel_wdata = gnt ? rq_wdata[63:32]             : rq_wdata[31:0];
      sel_wstrb = gnt ? rq_wstrb[7:4]               : rq_wstrb[3:0];
   end

   logic unused_bits;
   assign unused_bits = ^{sel_addr[1:0], m_axi.bresp[0], m_axi.rresp[0]};

`ifdef ZORRO_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] tmo_cnt;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
`endif

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state         <= IDLE;
         last          <= 1'b1;
         grant         <= 1'b0;
         rq_done       <= '0;
         rq_err        <= '0;
         rq_rdata      <= '0;
         m_axi.awaddr  <= '0;
         m_axi.awvalid <= 1'b0;
         m_axi.wdata   <= '0;
         m_axi.wstrb   <= '0;
         m_axi.wvalid  <= 1'b0;
         m_axi.bready  <= 1'b0;
         m_axi.araddr  <= '0;
         m_axi.arvalid <= 1'b0;
         m_axi.rready  <= 1'b0;
`ifdef ZORRO_ARB_TIMEOUT_EN
         tmo_cnt       <= '0;
`endif
      end else begin
         rq_done <= '0;
         rq_err  <= '0;
         case (state)
            IDLE: begin
               if (|rq_valid) begin
                  grant <= gnt;
                  last  <= gnt;
                  if (sel_we) begin
                     m_axi.awaddr  <= {sel_addr[ADDR_W-1:2], 2'b00};
                     m_axi.wdata   <= sel_wdata;
                     m_axi.wstrb   <= sel_wstrb;
                     m_axi.awvalid <= 1'b1;
                     m_axi.wvalid  <= 1'b1;
                     state         <= WADDR;
                  end else begin
                     m_axi.araddr  <= {sel_addr[ADDR_W-1:2], 2'b00};
                     m_axi.arvalid <= 1'b1;
                     state         <= RADDR;
                  end
               end
            end
            // AW and W complete independently; leave once neither is pending.
            WADDR: begin
               if (m_axi.awvalid && m_axi.awready) m_axi.awvalid <= 1'b0;
               if (m_axi.wvalid && m_axi.wready)   m_axi.wvalid  <= 1'b0;
               if ((!m_axi.awvalid || m_axi.awready) && (!m_axi.wvalid || m_axi.wready)) begin
                  m_axi.bready <= 1'b1;
                  state        <= WRESP;
               end
            end
            WRESP: begin
               if (m_axi.bvalid) begin
                  m_axi.bready   <= 1'b0;
                  rq_done[grant] <= 1'b1;
                  rq_err[grant]  <= m_axi.bresp[1];
                  state          <= DONE;
               end
            end
            RADDR: begin
               if (m_axi.arready) begin
                  m_axi.arvalid <= 1'b0;
                  m_axi.rready  <= 1'b1;
                  state         <= RDATA;
               end
            end
            RDATA: begin
               if (m_axi.rvalid) begin
                  m_axi.rready   <= 1'b0;
                  rq_rdata       <= m_axi.rdata;
                  rq_done[grant] <= 1'b1;
                  rq_err[grant]  <= m_axi.rresp[1];
                  state          <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
`ifdef ZORRO_ARB_TIMEOUT_EN
         // Watchdog overrides whatever the case statement decided this cycle.
         if (state inside {WADDR, WRESP, RADDR, RDATA}) begin
            if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
               m_axi.awvalid  <= 1'b0;
               m_axi.wvalid   <= 1'b0;
               m_axi.bready   <= 1'b0;
               m_axi.arvalid  <= 1'b0;
               m_axi.rready   <= 1'b0;
               rq_rdata       <= '0;
               rq_done[grant] <= 1'b1;
               rq_err[grant]  <= 1'b1;
               state          <= DONE;
               tmo_cnt        <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
         end else begin
            tmo_cnt <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_zorro_axil_reg_arbiter.sv
// tb_zorro_axil_reg_arbiter
//   Bench for zorro_axil_reg_arbiter: AXI4-Lite slave with per-channel stall
//   and response knobs, plus a word-array model of the four registers and
//   latency arithmetic for the expected results.
module tb_zorro_axil_reg_arbiter;
   localparam int ADDR_W = 4;

   logic                ACLK = 1'b0;
   logic                ARESET = 1'b1;
   logic [1:0]          rq_valid = '0;
   logic [1:0]          rq_we = '0;
   logic [2*ADDR_W-1:0] rq_addr = '0;
   logic [63:0]         rq_wdata = '0;
   logic [7:0]          rq_wstrb = '0;
   logic [1:0]          rq_done;
   logic [1:0]          rq_err;
   logic [31:0]         rq_rdata;

   zorro_axil_reg_arbiter_if #(.ADDR_W(ADDR_W)) m_axi ();

   zorro_axil_reg_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
      .ACLK     (ACLK),
      .ARESET   (ARESET),
      .rq_valid (rq_valid),
      .rq_we    (rq_we),
      .rq_addr  (rq_addr),
      .rq_wdata (rq_wdata),
      .rq_wstrb (rq_wstrb),
      .rq_done  (rq_done),
      .rq_err   (rq_err),
      .rq_rdata (rq_rdata),
      .m_axi    (m_axi)
   );

   always #5 ACLK = ~ACLK;

   int errors = 0;
   int checks = 0;

   // ---------------- slave model ----------------
   int unsigned aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic        ar_never = 1'b0;
   logic [1:0]  b_resp_k = 2'b00, r_resp_k = 2'b00;

   logic [31:0] smem [4];
   int unsigned aw_wait, w_wait, b_wait, ar_wait, r_wait;
   logic        aw_got, w_got, b_pend, r_pend;
   logic [1:0]  aw_idx;
   logic [31:0] s_wd, s_rdata;
   logic [3:0]  s_ws;
   logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

   assign m_axi.awready = m_axi.awvalid && (aw_wait >= aw_dly);
   assign m_axi.wready  = m_axi.wvalid && (w_wait >= w_dly);
   assign m_axi.bvalid  = b_pend && (b_wait >= b_dly);
   assign m_axi.bresp   = b_resp_k;
   assign m_axi.arready = m_axi.arvalid && !ar_never && (ar_wait >= ar_dly);
   assign m_axi.rvalid  = r_pend && (r_wait >= r_dly);
   assign m_axi.rresp   = r_resp_k;
   assign m_axi.rdata   = s_rdata;

   assign aw_hs = m_axi.awvalid && m_axi.awready;
   assign w_hs  = m_axi.wvalid && m_axi.wready;
   assign b_hs  = m_axi.bvalid && m_axi.bready;
   assign ar_hs = m_axi.arvalid && m_axi.arready;
   assign r_hs  = m_axi.rvalid && m_axi.rready;

   always @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
         aw_idx <= '0; s_wd <= '0; s_ws <= '0; s_rdata <= '0;
         for (int i = 0; i < 4; i++) smem[i] <= '0;
      end else begin
         aw_wait <= (m_axi.awvalid && !m_axi.awready) ? aw_wait + 1 : 0;
         w_wait  <= (m_axi.wvalid && !m_axi.wready) ? w_wait + 1 : 0;
         ar_wait <= (m_axi.arvalid && !m_axi.arready) ? ar_wait + 1 : 0;
         b_wait  <= (b_pend && !m_axi.bvalid) ? b_wait + 1 : 0;
         r_wait  <= (r_pend && !m_axi.rvalid) ? r_wait + 1 : 0;
         if (aw_hs) aw_idx <= m_axi.awaddr[3:2];
         if (w_hs) begin s_wd <= m_axi.wdata; s_ws <= m_axi.wstrb; end
         if ((aw_got || aw_hs) && (w_got || w_hs) && !b_pend) begin
            b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
         end else begin
            if (aw_hs) aw_got <= 1'b1;
            if (w_hs)  w_got  <= 1'b1;
         end
         if (b_hs) begin
            b_pend <= 1'b0;
            if (!b_resp_k[1])
               for (int i = 0; i < 4; i++)
                  if (s_ws[i]) smem[aw_idx][8*i +: 8] <= s_wd[8*i +: 8];
         end
         if (ar_hs) begin r_pend <= 1'b1; s_rdata <= smem[m_axi.araddr[3:2]]; end
         if (r_hs)  r_pend <= 1'b0;
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] exp_mem [4];
   int          model_last = 1;

   // ---------------- command driver (no checking) ----------------
   int          obs_lat, obs_awv, obs_wv, obs_arv;
   logic [1:0]  obs_done, obs_err;
   logic [31:0] obs_rd;
   logic [3:0]  obs_awaddr, obs_araddr;

   task automatic run_cmd(input int r, input logic we, input logic [3:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws);
      obs_lat = 0; obs_awv = 0; obs_wv = 0; obs_arv = 0;
      obs_done = '0; obs_err = '0; obs_rd = '0; obs_awaddr = '0; obs_araddr = '0;
      @(posedge ACLK); #1;
      rq_we[r] = we;
      rq_addr[r*4 +: 4] = addr;
      rq_wdata[r*32 +: 32] = wd;
      rq_wstrb[r*4 +: 4] = ws;
      rq_valid[r] = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         @(posedge ACLK); #1;
         if (m_axi.awvalid) begin obs_awv++; obs_awaddr = m_axi.awaddr; end
         if (m_axi.wvalid)  obs_wv++;
         if (m_axi.arvalid) begin obs_arv++; obs_araddr = m_axi.araddr; end
         if (rq_done != 2'b00) begin
            obs_lat = c; obs_done = rq_done; obs_err = rq_err; obs_rd = rq_rdata;
            break;
         end
      end
      rq_valid[r] = 1'b0;
      @(posedge ACLK); #1;
   endtask

   task automatic do_reset();
      @(posedge ACLK); #2;
      ARESET = 1'b1;
      rq_valid = '0;
      repeat (2) @(posedge ACLK);
      #2;
      ARESET = 1'b0;
      model_last = 1;
      for (int i = 0; i < 4; i++) exp_mem[i] = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1;
      checks++;
      if ({rq_done, rq_err, m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got done=%b err=%b aw=%b w=%b b=%b ar=%b r=%b want all 0",
                  rq_done, rq_err, m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready);
      end
      checks++;
      if ({rq_rdata, m_axi.awaddr, m_axi.araddr, m_axi.wdata, m_axi.wstrb} !== '0) begin
         errors++;
         $display("FAIL reset_data: got rdata=%h awaddr=%h araddr=%h wdata=%h wstrb=%h want 0",
                  rq_rdata, m_axi.awaddr, m_axi.araddr, m_axi.wdata, m_axi.wstrb);
      end
      repeat (3) @(posedge ACLK);
      #2;
      ARESET = 1'b0;
      for (int i = 0; i < 4; i++) exp_mem[i] = '0;
      model_last = 1;
      @(posedge ACLK); #1;
      checks++;
      if ({rq_done, m_axi.awvalid, m_axi.wvalid, m_axi.arvalid} !== '0) begin
         errors++;
         $display("FAIL reset_idle: got done=%b aw=%b w=%b ar=%b want 0",
                  rq_done, m_axi.awvalid, m_axi.wvalid, m_axi.arvalid);
      end
   endtask

   task automatic test_basic();
      run_cmd(0, 1'b1, 4'h4, 32'h0000_0001, 4'hF);
      exp_mem[1] = 32'h0000_0001; model_last = 0;
      checks++;
      if (obs_awaddr !== 4'h4) begin errors++; $display("FAIL basic_awaddr: got %h want 4", obs_awaddr); end
      checks++;
      if (obs_lat !== 3) begin errors++; $display("FAIL basic_wr_lat: got %0d want 3", obs_lat); end
      checks++;
      if (obs_done !== 2'b01 || obs_err !== 2'b00) begin
         errors++; $display("FAIL basic_wr_done: got done=%b err=%b want 01/00", obs_done, obs_err);
      end
      run_cmd(0, 1'b0, 4'h4, 32'h0, 4'h0);
      checks++;
      if (obs_araddr !== 4'h4) begin errors++; $display("FAIL basic_araddr: got %h want 4", obs_araddr); end
      checks++;
      if (obs_lat !== 3) begin errors++; $display("FAIL basic_rd_lat: got %0d want 3", obs_lat); end
      checks++;
      if (obs_rd !== exp_mem[1] || obs_done !== 2'b01 || obs_err !== 2'b00) begin
         errors++; $display("FAIL basic_rd: got rdata=%h done=%b err=%b want %h/01/00", obs_rd, obs_done, obs_err, exp_mem[1]);
      end
   endtask

   task automatic test_w_stall();
      w_dly = 4;
      run_cmd(0, 1'b1, 4'hC, 32'hCAFE_F00D, 4'hF);
      w_dly = 0;
      exp_mem[3] = 32'hCAFE_F00D; model_last = 0;
      checks++;
      if (obs_awv !== 1) begin errors++; $display("FAIL wstall_awvalid_cycles: got %0d want 1", obs_awv); end
      checks++;
      if (obs_wv !== 5) begin errors++; $display("FAIL wstall_wvalid_cycles: got %0d want 5", obs_wv); end
      checks++;
      if (obs_lat !== 7) begin errors++; $display("FAIL wstall_lat: got %0d want 7", obs_lat); end
   endtask

   task automatic test_bresp_err();
      b_resp_k = 2'b10;
      run_cmd(0, 1'b1, 4'h0, 32'h1234_5678, 4'hF);
      b_resp_k = 2'b00;
      model_last = 0;
      checks++;
      if (obs_done !== 2'b01 || obs_err !== 2'b01) begin
         errors++; $display("FAIL bresp_err: got done=%b err=%b want 01/01", obs_done, obs_err);
      end
   endtask

`ifdef ZORRO_ARB_TIMEOUT_EN
   task automatic test_timeout();
      ar_never = 1'b1;
      run_cmd(0, 1'b0, 4'hC, 32'h0, 4'h0);
      ar_never = 1'b0;
      model_last = 0;
      checks++;
      if (obs_arv !== 16) begin errors++; $display("FAIL tmo_arvalid_cycles: got %0d want 16", obs_arv); end
      checks++;
      if (obs_lat !== 17) begin errors++; $display("FAIL tmo_lat: got %0d want 17", obs_lat); end
      checks++;
      if (obs_done !== 2'b01 || obs_err !== 2'b01 || obs_rd !== 32'h0) begin
         errors++; $display("FAIL tmo_result: got done=%b err=%b rdata=%h want 01/01/0", obs_done, obs_err, obs_rd);
      end
   endtask
`endif

   task automatic test_arbitration();
      int order [4];
      int n;
      logic both;
      logic [1:0] seen;
      logic [1:0] err0;
      logic [1:0] err1;
      logic [31:0] rd1;
      do_reset();
      run_cmd(1, 1'b1, 4'h8, 32'h5A5A_1234, 4'hF);
      exp_mem[2] = 32'h5A5A_1234; model_last = 1;
      for (int i = 0; i < 4; i++) order[i] = -1;
      n = 0;
      for (int rnd = 0; rnd < 2; rnd++) begin
         int exp_first;
         exp_first = 1 - model_last;
         both = 1'b0; seen = '0; err0 = '0; err1 = '0; rd1 = '0;
         @(posedge ACLK); #1;
         rq_we = 2'b01;
         rq_addr = {4'h8, 4'h0};
         rq_wdata = {32'h0, 32'h0000_00AA};
         rq_wstrb = 8'h0F;
         rq_valid = 2'b11;
         for (int c = 1; c <= 60 && seen != 2'b11; c++) begin
            @(posedge ACLK); #1;
            if (rq_done == 2'b11) both = 1'b1;
            if (rq_done[0]) begin
               seen[0] = 1'b1; err0 = rq_err; rq_valid[0] = 1'b0;
               if (n < 4) begin order[n] = 0; n++; end
            end
            if (rq_done[1]) begin
               seen[1] = 1'b1; err1 = rq_err; rd1 = rq_rdata; rq_valid[1] = 1'b0;
               if (n < 4) begin order[n] = 1; n++; end
            end
         end
         rq_valid = '0;
         @(posedge ACLK); #1;
         exp_mem[0] = 32'h0000_00AA;
         checks++;
         if (seen !== 2'b11 || both !== 1'b0) begin
            errors++; $display("FAIL arb_done[%0d]: got seen=%b both=%b want 11/0", rnd, seen, both);
         end
         checks++;
         if (order[2*rnd] !== exp_first || order[2*rnd+1] !== 1 - exp_first) begin
            errors++; $display("FAIL arb_order[%0d]: got %0d,%0d want %0d,%0d", rnd,
                               order[2*rnd], order[2*rnd+1], exp_first, 1 - exp_first);
         end
         checks++;
         if (rd1 !== exp_mem[2] || err0 !== 2'b00 || err1 !== 2'b00) begin
            errors++; $display("FAIL arb_data[%0d]: got rdata=%h err0=%b err1=%b want %h/00/00", rnd, rd1, err0, err1, exp_mem[2]);
         end
         model_last = 1 - exp_first;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         int r;
         logic we;
         logic [3:0] addr;
         logic [31:0] wd;
         logic [3:0] ws;
         logic e;
         logic [1:0] resp;
         int unsigned ab_max;
         int exp_lat;
         logic [31:0] exp_rd;
         r = $urandom_range(0, 1);
         we = 1'($urandom_range(0, 1));
         addr = 4'($urandom_range(0, 15));
         wd = $urandom;
         ws = 4'($urandom_range(0, 15));
         aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
         ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
         e = ($urandom_range(0, 3) == 0);
         if (e) resp = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
         else   resp = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01;
         b_resp_k = resp; r_resp_k = resp;
         exp_rd = exp_mem[addr / 4];
         ab_max = (aw_dly > w_dly) ? aw_dly : w_dly;
         exp_lat = we ? 3 + int'(ab_max) + int'(b_dly) : 3 + int'(ar_dly) + int'(r_dly);
         run_cmd(r, we, addr, wd, ws);
         if (we && !e)
            for (int b = 0; b < 4; b++)
               if (ws[b]) exp_mem[addr / 4][8*b +: 8] = wd[8*b +: 8];
         model_last = r;
         checks++;
         if (obs_lat !== exp_lat) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", i, obs_lat, exp_lat); end
         checks++;
         if (obs_done !== (2'b01 << r) || obs_err !== (e ? (2'b01 << r) : 2'b00)) begin
            errors++; $display("FAIL rnd_status[%0d]: got done=%b err=%b want req %0d err %b", i, obs_done, obs_err, r, e);
         end
         checks++;
         if (we ? (obs_awaddr !== (addr & 4'hC)) : (obs_araddr !== (addr & 4'hC))) begin
            errors++; $display("FAIL rnd_addr[%0d]: got aw=%h ar=%h want %h", i, obs_awaddr, obs_araddr, addr & 4'hC);
         end
         if (!we) begin
            checks++;
            if (obs_rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, obs_rd, exp_rd); end
         end
      end
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
      b_resp_k = 2'b00; r_resp_k = 2'b00;
   endtask

   task automatic test_mid_reset();
      logic in_wresp;
      in_wresp = 1'b0;
      b_dly = 6;
      @(posedge ACLK); #1;
      rq_we[0] = 1'b1; rq_addr[3:0] = 4'h8; rq_wdata[31:0] = 32'hDEAD_BEEF; rq_wstrb[3:0] = 4'hF;
      rq_valid[0] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge ACLK); #1;
         if (m_axi.bready) begin in_wresp = 1'b1; break; end
      end
      checks++;
      if (in_wresp !== 1'b1) begin errors++; $display("FAIL mreset_reach_wresp: got bready=%b want 1", in_wresp); end
      #2;
      ARESET = 1'b1;
      rq_valid = '0;
      #1;
      checks++;
      if ({rq_done, rq_err, rq_rdata, m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready,
           m_axi.awaddr, m_axi.wdata, m_axi.wstrb} !== '0) begin
         errors++;
         $display("FAIL mreset_async: got done=%b err=%b rdata=%h bready=%b awaddr=%h wdata=%h want 0",
                  rq_done, rq_err, rq_rdata, m_axi.bready, m_axi.awaddr, m_axi.wdata);
      end
      b_dly = 0;
      repeat (2) @(posedge ACLK);
      #2;
      ARESET = 1'b0;
      model_last = 1;
      for (int i = 0; i < 4; i++) exp_mem[i] = '0;
      run_cmd(0, 1'b1, 4'h8, 32'h0BAD_F00D, 4'h3);
      exp_mem[2][15:0] = 16'hF00D;
      checks++;
      if (obs_lat !== 3 || obs_done !== 2'b01 || obs_err !== 2'b00) begin
         errors++; $display("FAIL mreset_after_wr: got lat=%0d done=%b err=%b want 3/01/00", obs_lat, obs_done, obs_err);
      end
      run_cmd(1, 1'b0, 4'h8, 32'h0, 4'h0);
      checks++;
      if (obs_lat !== 3 || obs_done !== 2'b10 || obs_rd !== exp_mem[2]) begin
         errors++; $display("FAIL mreset_after_rd: got lat=%0d done=%b rdata=%h want 3/10/%h", obs_lat, obs_done, obs_rd, exp_mem[2]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_w_stall();
      test_bresp_err();
`ifdef ZORRO_ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_arbitration();
      test_random();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
